// File: rtl/mod5_serial_tx.sv
// Serial transmitter: shifts a DATA_W-bit payload out MSB-first, then appends a
// 3-bit check field so the whole frame value (din*8 + c) is a multiple of 5.
module mod5_serial_tx #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              dout,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_first,
    output logic              dout_last
);

    localparam int unsigned     CntW    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

    typedef enum logic [1:0] {StIdle, StData, StCheck} state_e;

    state_e            state_q;
    logic [DATA_W-1:0] shift_q;
    logic [CntW-1:0]   cnt_q;
    logic [2:0]        rem_q;
    // Holds c[1:0] once c[2] has moved into dout_q.
    logic [1:0]        chk_q;
    logic [1:0]        chk_cnt_q;
    logic              dout_q;
    logic              dout_valid_q;
    logic              dout_first_q;
    logic              dout_last_q;

    logic [DATA_W-1:0] shift_nxt;
    logic [2:0]        rem_nxt;
    logic [2:0]        chk_new;
    logic              out_hs;

    // rem <- (2*rem + b) mod 5 as a plain 5-state transition table.
    function automatic logic [2:0] rem_step(input logic [2:0] rem, input logic b);
        logic [2:0] r;
        case ({rem, b})
            4'b000_0: r = 3'd0;
            4'b000_1: r = 3'd1;
            4'b001_0: r = 3'd2;
            4'b001_1: r = 3'd3;
            4'b010_0: r = 3'd4;
            4'b010_1: r = 3'd0;
            4'b011_0: r = 3'd1;
            4'b011_1: r = 3'd2;
            4'b100_0: r = 3'd3;
            4'b100_1: r = 3'd4;
            default:  r = 3'd0;
        endcase
        return r;
    endfunction

    // Check value that cancels payload remainder r: (3*r + c) mod 5 == 0.
    function automatic logic [2:0] chk_of(input logic [2:0] r);
        logic [2:0] c;
        case (r)
            3'd0:    c = 3'd0;
            3'd1:    c = 3'd2;
            3'd2:    c = 3'd4;
            3'd3:    c = 3'd1;
            3'd4:    c = 3'd3;
            default: c = 3'd0;
        endcase
        return c;
    endfunction

    // Next-beat helpers derived from current state.
    always_comb begin
        shift_nxt = shift_q << 1;
        rem_nxt   = rem_step(rem_q, shift_q[DATA_W-1]);
        chk_new   = chk_of(rem_nxt);
        out_hs    = dout_valid_q && dout_ready;
    end

    // Frame FSM with all outputs registered; every update is gated by the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            shift_q      <= '0;
            cnt_q        <= '0;
            rem_q        <= 3'd0;
            chk_q        <= 2'd0;
            chk_cnt_q    <= 2'd0;
            dout_q       <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_first_q <= 1'b0;
            dout_last_q  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (din_valid) begin
                        state_q      <= StData;
                        shift_q      <= din;
                        cnt_q        <= '0;
                        rem_q        <= 3'd0;
                        dout_q       <= din[DATA_W-1];
                        dout_valid_q <= 1'b1;
                        dout_first_q <= 1'b1;
                        dout_last_q  <= 1'b0;
                    end
                end
                StData: begin
                    if (out_hs) begin
                        shift_q      <= shift_nxt;
                        rem_q        <= rem_nxt;
                        cnt_q        <= cnt_q + 1'b1;
                        dout_first_q <= 1'b0;
                        if (cnt_q == CntLast) begin
                            state_q   <= StCheck;
                            dout_q    <= chk_new[2];
                            chk_q     <= chk_new[1:0];
                            chk_cnt_q <= 2'd0;
                        end else begin
                            dout_q <= shift_nxt[DATA_W-1];
                        end
                    end
                end
                StCheck: begin
                    if (out_hs) begin
                        if (chk_cnt_q == 2'd2) begin
                            state_q      <= StIdle;
                            dout_q       <= 1'b0;
                            dout_valid_q <= 1'b0;
                            dout_last_q  <= 1'b0;
                        end else begin
                            chk_cnt_q   <= chk_cnt_q + 1'b1;
                            dout_q      <= chk_q[1];
                            chk_q       <= {chk_q[0], 1'b0};
                            dout_last_q <= (chk_cnt_q == 2'd1);
                        end
                    end
                end
                default: begin
                    state_q      <= StIdle;
                    dout_valid_q <= 1'b0;
                    dout_first_q <= 1'b0;
                    dout_last_q  <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = (state_q == StIdle) && !reset;
    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign dout_first = dout_first_q;
    assign dout_last  = dout_last_q;

endmodule

// File: tb/tb_mod5_serial_tx.sv
// Directed bench for mod5_serial_tx: DATA_W=8 and DATA_W=1 instances.
module tb_mod5_serial_tx;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       din_valid, din_ready, dout, dout_valid, dout_ready, dout_first, dout_last;
    logic [0:0] d1_din;
    logic       d1_din_valid, d1_din_ready, d1_dout, d1_dout_valid, d1_dout_ready;
    logic       d1_dout_first, d1_dout_last;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    mod5_serial_tx #(.DATA_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_first (dout_first),
        .dout_last  (dout_last)
    );

    mod5_serial_tx #(.DATA_W(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .din        (d1_din),
        .din_valid  (d1_din_valid),
        .din_ready  (d1_din_ready),
        .dout       (d1_dout),
        .dout_valid (d1_dout_valid),
        .dout_ready (d1_dout_ready),
        .dout_first (d1_dout_first),
        .dout_last  (d1_dout_last)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a falling edge with the block idle; the word is taken on the next rise.
    task automatic accept8(input logic [7:0] w);
        check_eq("idle_ready", 32'(din_ready), 32'd1);
        din       = w;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
    endtask

    // mode 0: sink always ready; 1: stalls; 2: din_valid held high with churning din.
    task automatic collect8(input int mode, input logic [10:0] exp, input string tag);
        logic [10:0] fr;
        int          beats;
        int          cyc;
        int          trk;
        logic        held, rdy, pd, pf, pl;
        fr = '0; beats = 0; cyc = 0; trk = 0; held = 1'b0;
        pd = 1'b0; pf = 1'b0; pl = 1'b0;
        while (beats < 11 && cyc < 400) begin
            cyc++;
            if (held) begin
                check_eq({tag, "/hold_dout"}, 32'(dout), 32'(pd));
                check_eq({tag, "/hold_first"}, 32'(dout_first), 32'(pf));
                check_eq({tag, "/hold_last"}, 32'(dout_last), 32'(pl));
            end
            check_eq({tag, "/valid"}, 32'(dout_valid), 32'd1);
            if (mode == 2) begin
                check_eq({tag, "/busy_ready"}, 32'(din_ready), 32'd0);
                din = 8'($urandom);
            end
            rdy = (mode == 1) ? !((cyc % 3 == 1) || ($urandom_range(0, 3) == 0)) : 1'b1;
            dout_ready = rdy;
            if (rdy) begin
                fr = {fr[9:0], dout};
                check_eq({tag, "/first"}, 32'(dout_first), 32'(beats == 0));
                check_eq({tag, "/last"}, 32'(dout_last), 32'(beats == 10));
                trk = (2 * trk + int'(dout)) % 5;
                beats++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                pd = dout; pf = dout_first; pl = dout_last;
            end
            @(negedge clk);
        end
        dout_ready = 1'b1;
        check_eq({tag, "/beats"}, 32'(beats), 32'd11);
        check_eq({tag, "/frame"}, 32'(fr), 32'(exp));
        check_eq({tag, "/mod5"}, 32'(trk), 32'd0);
        check_eq({tag, "/end_valid"}, 32'(dout_valid), 32'd0);
        check_eq({tag, "/end_ready"}, 32'(din_ready), 32'd1);
        check_eq({tag, "/end_flags"}, 32'({dout_first, dout_last}), 32'd0);
        if (mode == 2) din = 8'h0D;
    endtask

    logic [7:0]  words  [5] = '{8'h01, 8'h07, 8'h0D, 8'hFF, 8'h00};
    logic [10:0] frames [5] = '{11'd10, 11'd60, 11'd105, 11'd2040, 11'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] fr1;
        reset = 1'b1;
        din = '0; din_valid = 1'b0; dout_ready = 1'b1;
        d1_din = '0; d1_din_valid = 1'b0; d1_dout_ready = 1'b1;
        repeat (2) @(negedge clk);
        check_eq("rst_valid", 32'(dout_valid), 32'd0);
        check_eq("rst_dout", 32'(dout), 32'd0);
        check_eq("rst_flags", 32'({dout_first, dout_last}), 32'd0);
        check_eq("rst_ready_gated", 32'(din_ready), 32'd0);
        check_eq("rst_d1_valid", 32'(d1_dout_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("post_rst_ready", 32'(din_ready), 32'd1);

        // Back-to-back directed frames with the minimum one-cycle gap.
        for (int i = 0; i < 5; i++) begin
            accept8(words[i]);
            collect8(0, frames[i], $sformatf("w%0h", words[i]));
        end

        // Stalled sink: 165*8 = 1320, check field 000.
        accept8(8'hA5);
        collect8(1, 11'd1320, "stall_a5");

        // din_valid held high through a frame; second word taken after the gap.
        din = 8'h01;
        din_valid = 1'b1;
        @(negedge clk);
        collect8(2, 11'd10, "busy_first");
        @(negedge clk);
        din_valid = 1'b0;
        collect8(0, 11'd105, "busy_second");

        // Reset while beat 5 is on the line.
        accept8(8'h5A);
        repeat (4) @(negedge clk);
        check_eq("abort_mid_valid", 32'(dout_valid), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_valid", 32'(dout_valid), 32'd0);
        check_eq("abort_last", 32'(dout_last), 32'd0);
        check_eq("abort_ready_gated", 32'(din_ready), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_eq("abort_ready", 32'(din_ready), 32'd1);
        check_eq("abort_still_idle", 32'(dout_valid), 32'd0);
        accept8(8'h01);
        collect8(0, 11'd10, "after_abort");

        // DATA_W=1 build: din=1 gives stream 1_010.
        fr1 = '0;
        check_eq("d1_ready", 32'(d1_din_ready), 32'd1);
        d1_din = 1'b1;
        d1_din_valid = 1'b1;
        @(negedge clk);
        d1_din_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq("d1_valid", 32'(d1_dout_valid), 32'd1);
            check_eq("d1_first", 32'(d1_dout_first), 32'(i == 0));
            check_eq("d1_last", 32'(d1_dout_last), 32'(i == 3));
            fr1 = {fr1[2:0], d1_dout};
            @(negedge clk);
        end
        check_eq("d1_frame", 32'(fr1), 32'd10);
        check_eq("d1_end_valid", 32'(d1_dout_valid), 32'd0);
        check_eq("d1_end_ready", 32'(d1_din_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
